// File: rtl/imm_gen_pipe.sv
// Immediate generator for the decode stage: opcode-driven format decode, XLEN
// extension, and a STAGES-deep elastic valid/ready pipeline with flush.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       imm_fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_I       = 3'd0;
    localparam logic [2:0] FMT_B       = 3'd1;
    localparam logic [2:0] FMT_S       = 3'd2;
    localparam logic [2:0] FMT_J       = 3'd3;
    localparam logic [2:0] FMT_U       = 3'd4;
    localparam logic [2:0] FMT_NONE    = 3'd5;
    localparam logic [2:0] FMT_SHAMT   = 3'd6;
    localparam logic [2:0] FMT_ILLEGAL = 3'd7;

    localparam int LAST = STAGES - 1;

    logic [2:0]      fmt_dec;
    logic [31:0]     imm32_dec;
    logic [XLEN-1:0] imm_dec;
    logic            sign_bit;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] ill_q, ill_d;
    logic [STAGES-1:0] stage_ready;
    logic [XLEN-1:0]   imm_q [STAGES];
    logic [XLEN-1:0]   imm_d [STAGES];
    logic [2:0]        fmt_q [STAGES];
    logic [2:0]        fmt_d [STAGES];

    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        fmt_dec = FMT_ILLEGAL;
        case (instr[6:0])
            7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: fmt_dec = FMT_I;
            7'b0010011: fmt_dec = (instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
            7'b0100011: fmt_dec = FMT_S;
            7'b1100011: fmt_dec = FMT_B;
            7'b1101111: fmt_dec = FMT_J;
            7'b0110111, 7'b0010111: fmt_dec = FMT_U;
            7'b0110011: fmt_dec = FMT_NONE;
            default:    fmt_dec = FMT_ILLEGAL;
        endcase
    end

    // Build a 32-bit sign-correct value first, then widen by replicating bit 31.
    always_comb begin
        sign_bit  = instr[31];
        imm32_dec = 32'd0;
        imm_dec   = {XLEN{1'b0}};
        case (fmt_dec)
            FMT_I: imm32_dec = {{20{sign_bit}}, instr[31:20]};
            FMT_S: imm32_dec = {{20{sign_bit}}, instr[31:25], instr[11:7]};
            FMT_B: imm32_dec = {{19{sign_bit}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            FMT_J: imm32_dec = {{11{sign_bit}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            FMT_U: imm32_dec = {instr[31:12], 12'd0};
            default: imm32_dec = 32'd0;
        endcase
        if (fmt_dec == FMT_SHAMT) begin
            imm_dec[5:0] = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
        end else begin
            imm_dec        = {XLEN{imm32_dec[31]}};
            imm_dec[31:0]  = imm32_dec;
        end
    end

    // A stage can load if it or any stage downstream of it has a free slot.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_ready[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!valid_q[j]) begin
                    stage_ready[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = stage_ready[0] && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q[LAST] && out_ready;

    always_comb begin
        valid_d = valid_q;
        ill_d   = ill_q;
        for (int i = 0; i < STAGES; i++) begin
            imm_d[i] = imm_q[i];
            fmt_d[i] = fmt_q[i];
        end
        if (stage_ready[0]) begin
            valid_d[0] = in_fire;
            if (in_fire) begin
                imm_d[0] = imm_dec;
                fmt_d[0] = fmt_dec;
                ill_d[0] = (fmt_dec == FMT_ILLEGAL);
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (stage_ready[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    imm_d[i] = imm_q[i-1];
                    fmt_d[i] = fmt_q[i-1];
                    ill_d[i] = ill_q[i-1];
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (out_fire && ill_q[LAST] && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            ill_q         <= '0;
            illegal_cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            ill_q         <= ill_d;
            illegal_cnt_q <= illegal_cnt_d;
            for (int i = 0; i < STAGES; i++) begin
                imm_q[i] <= imm_d[i];
                fmt_q[i] <= fmt_d[i];
            end
        end
    end

    assign out_valid   = valid_q[LAST];
    assign imm         = imm_q[LAST];
    assign imm_fmt     = fmt_q[LAST];
    assign illegal     = ill_q[LAST];
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (XLEN=32, XLEN=64, CNT_W=2)
// share one stimulus stream; every expected value is hand-computed.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready, out_valid, illegal;
    logic [31:0] imm;
    logic [2:0]  imm_fmt;
    logic [15:0] illegal_cnt;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [2:0]  imm_fmt64;
    logic [15:0] illegal_cnt64;

    logic        in_ready_c, out_valid_c, illegal_c;
    logic [31:0] imm_c;
    logic [2:0]  imm_fmt_c;
    logic [1:0]  illegal_cnt_c;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .imm(imm),
        .imm_fmt(imm_fmt), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(2), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
        .imm_fmt(imm_fmt64), .illegal(illegal64), .illegal_cnt(illegal_cnt64)
    );

    imm_gen_pipe #(.XLEN(32), .STAGES(2), .CNT_W(2)) dutc (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
        .instr(instr), .out_valid(out_valid_c), .out_ready(out_ready), .imm(imm_c),
        .imm_fmt(imm_fmt_c), .illegal(illegal_c), .illegal_cnt(illegal_cnt_c)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI = 32'hFFF00093;
    localparam logic [31:0] BEQ  = 32'hFE000EE3;
    localparam logic [31:0] SRAI = 32'h4030D093;
    localparam logic [31:0] LUI  = 32'h800002B7;
    localparam logic [31:0] JAL  = 32'h0080006F;
    localparam logic [31:0] SW   = 32'hFE512E23;
    localparam logic [31:0] ADD  = 32'h002081B3;

    logic [31:0] stream_in  [6];
    logic [31:0] stream_imm [6];
    logic [2:0]  stream_fmt [6];
    int sent, recv;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stream_in  = '{JAL, SW, ADD, ADDI, BEQ, SRAI};
        stream_imm = '{32'h8, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h3};
        stream_fmt = '{3'd3, 3'd2, 3'd5, 3'd0, 3'd1, 3'd6};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 32'd0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_imm", 64'(imm), 64'd0);
        chk("reset_fmt", 64'(imm_fmt), 64'd0);
        chk("reset_illegal", 64'(illegal), 64'd0);
        chk("reset_cnt", 64'(illegal_cnt), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // addi: two-cycle latency
        instr = ADDI; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("addi_not_yet", 64'(out_valid), 64'd0);
        tick();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
        chk("addi_fmt", 64'(imm_fmt), 64'd0);
        chk("addi_illegal", 64'(illegal), 64'd0);
        chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        tick();
        chk("addi_drained", 64'(out_valid), 64'd0);

        // beq then srai back to back
        instr = BEQ; in_valid = 1'b1;
        tick();
        instr = SRAI;
        tick();
        chk("beq_valid", 64'(out_valid), 64'd1);
        chk("beq_imm", 64'(imm), 64'hFFFFFFFC);
        chk("beq_fmt", 64'(imm_fmt), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("srai_valid", 64'(out_valid), 64'd1);
        chk("srai_imm", 64'(imm), 64'h3);
        chk("srai_fmt", 64'(imm_fmt), 64'd6);
        chk("srai_imm64", imm64, 64'h3);
        tick();

        // lui: upper bits sign-extended for XLEN=64
        instr = LUI; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("lui_fmt64", 64'(imm_fmt64), 64'd4);
        chk("lui_imm32", 64'(imm), 64'h80000000);
        tick();

        // six-entry stream with a three-cycle output stall
        sent = 0; recv = 0;
        for (int c = 0; c < 30 && recv < 6; c++) begin
            in_valid  = (sent < 6);
            instr     = (sent < 6) ? stream_in[sent] : 32'd0;
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
            end
            if (out_valid) begin
                chk($sformatf("stream_imm_%0d", recv), 64'(imm), 64'(stream_imm[recv]));
                chk($sformatf("stream_fmt_%0d", recv), 64'(imm_fmt), 64'(stream_fmt[recv]));
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) recv++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 64'(recv), 64'd6);
        chk("stream_no_extra", 64'(out_valid), 64'd0);

        // illegal opcodes and the counter
        instr = 32'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ill1_valid", 64'(out_valid), 64'd1);
        chk("ill1_illegal", 64'(illegal), 64'd1);
        chk("ill1_fmt", 64'(imm_fmt), 64'd7);
        chk("ill1_imm", 64'(imm), 64'd0);
        chk("ill1_cnt_before", 64'(illegal_cnt), 64'd0);
        tick();
        chk("ill1_cnt_after", 64'(illegal_cnt), 64'd1);
        chk("ill1_cntc", 64'(illegal_cnt_c), 64'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("ill2_valid", 64'(out_valid), 64'd1);
        chk("ill2_cnt_held", 64'(illegal_cnt), 64'd1);
        tick();
        chk("ill2_still_valid", 64'(out_valid), 64'd1);
        chk("ill2_cnt_no_hs", 64'(illegal_cnt), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("ill2_cnt_after", 64'(illegal_cnt), 64'd2);
        chk("ill2_cntc", 64'(illegal_cnt_c), 64'd2);
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("ill5_cnt", 64'(illegal_cnt), 64'd5);
        chk("cntc_saturated", 64'(illegal_cnt_c), 64'd3);

        // flush with a full pipe; the output handshake in that cycle completes
        out_ready = 1'b0; instr = 32'd0; in_valid = 1'b1;
        tick();
        instr = LUI;
        tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        instr = JAL; out_ready = 1'b1; flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_cnt", 64'(illegal_cnt), 64'd6);
        chk("flush_cntc", 64'(illegal_cnt_c), 64'd3);
        tick(); tick();
        chk("flush_no_ghost", 64'(out_valid), 64'd0);

        // asynchronous reset mid-stream
        instr = ADDI; in_valid = 1'b1;
        tick();
        instr = LUI;
        tick();
        chk("pre_rst_imm", 64'(imm), 64'hFFFFFFFF);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", 64'(imm), 64'd0);
        chk("rst_fmt", 64'(imm_fmt), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        chk("rst_cntc", 64'(illegal_cnt_c), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("post_rst_empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
